// File: rtl/coin_acceptor.sv
// rtl/coin_acceptor.sv - coin/cancel button front end: sync, debounce, one-pulse-per-press FSM
module coin_acceptor #(
    parameter int DB_CYCLES = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn5,
    input  logic       btn10,
    input  logic       btn20,
    input  logic       btn_cancel,
    input  logic       enable,
    output logic [1:0] coin,
    output logic       cancel_out,
    output logic       coin_reject,
    output logic [7:0] accept_count,
    output logic       busy
);

    typedef enum logic [1:0] {
        IDLE,
        PULSE,
        WAIT_RELEASE
    } state_t;

    // The counter has been incremented DB_CYCLES-1 times when it holds this value,
    // so the DB_CYCLES-th consecutive differing edge flips the level.
    localparam logic [7:0] DB_LAST = 8'(DB_CYCLES - 1);

    // Bit order everywhere: [0]=5 Rs, [1]=10 Rs, [2]=20 Rs, [3]=cancel
    logic [3:0] raw;
    logic [3:0] sync1;
    logic [3:0] sync2;
    logic [3:0] level;
    logic [7:0] db_cnt [4];

    state_t     state;

    logic       coin_any;
    logic       coin_multi;
    logic       any_level;
    logic [1:0] coin_code;

    assign raw = {btn_cancel, btn20, btn10, btn5};

    // Two-flop synchroniser per button
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= '0;
            sync2 <= '0;
        end else begin
            sync1 <= raw;
            sync2 <= sync1;
        end
    end

    // Debounce: level follows sync2 only after DB_CYCLES consecutive differing edges
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            level <= '0;
            for (int i = 0; i < 4; i++) begin
                db_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < 4; i++) begin
                if (sync2[i] == level[i]) begin
                    db_cnt[i] <= '0;
                end else if (db_cnt[i] == DB_LAST) begin
                    level[i]  <= sync2[i];
                    db_cnt[i] <= '0;
                end else begin
                    db_cnt[i] <= db_cnt[i] + 8'd1;
                end
            end
        end
    end

    assign any_level  = |level;
    assign coin_any   = |level[2:0];
    assign coin_multi = (level[0] & level[1]) | (level[0] & level[2]) | (level[1] & level[2]);
    // Valid only when exactly one coin level is high: 5->01, 10->10, 20->11
    assign coin_code  = {level[2] | level[1], level[2] | level[0]};

    // Press FSM with registered single-cycle outputs and the accepted-coin counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= IDLE;
            coin         <= 2'b00;
            cancel_out   <= 1'b0;
            coin_reject  <= 1'b0;
            accept_count <= 8'd0;
        end else begin
            coin        <= 2'b00;
            cancel_out  <= 1'b0;
            coin_reject <= 1'b0;
            case (state)
                IDLE: begin
                    if (level[3]) begin
                        cancel_out <= 1'b1;
                        state      <= PULSE;
                    end else if (coin_any) begin
                        if (!enable) begin
                            state <= WAIT_RELEASE;
                        end else if (coin_multi) begin
                            coin_reject <= 1'b1;
                            state       <= PULSE;
                        end else begin
                            coin         <= coin_code;
                            accept_count <= accept_count + 8'd1;
                            state        <= PULSE;
                        end
                    end
                end
                PULSE: begin
                    state <= WAIT_RELEASE;
                end
                WAIT_RELEASE: begin
                    if (!any_level) begin
                        state <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state != IDLE);

endmodule

// File: tb/tb_coin_acceptor.sv
// tb/tb_coin_acceptor.sv - directed vector bench for coin_acceptor
module tb_coin_acceptor;

    logic       clk;
    logic       reset;
    logic       btn5;
    logic       btn10;
    logic       btn20;
    logic       btn_cancel;
    logic       enable;
    logic [1:0] coin;
    logic       cancel_out;
    logic       coin_reject;
    logic [7:0] accept_count;
    logic       busy;

    int checks = 0;
    int errors = 0;

    int n_coin   = 0;
    int n_cancel = 0;
    int n_reject = 0;
    logic [1:0] last_coin = 2'b00;

    coin_acceptor #(.DB_CYCLES(4)) dut (
        .clk          (clk),
        .reset        (reset),
        .btn5         (btn5),
        .btn10        (btn10),
        .btn20        (btn20),
        .btn_cancel   (btn_cancel),
        .enable       (enable),
        .coin         (coin),
        .cancel_out   (cancel_out),
        .coin_reject  (coin_reject),
        .accept_count (accept_count),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] btns;     // {cancel, 20, 10, 5}
        logic       en;
        logic [1:0] code;
        int         n_coin;
        int         n_cancel;
        int         n_rej;
        int         inc;
    } vec_t;

    vec_t tbl [10];

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse monitor sampled mid-cycle
    always @(negedge clk) begin
        if (coin != 2'b00) begin
            n_coin    = n_coin + 1;
            last_coin = coin;
        end
        if (cancel_out)  n_cancel = n_cancel + 1;
        if (coin_reject) n_reject = n_reject + 1;
        if (coin != 2'b00 || cancel_out || coin_reject)
            check("exclusive", int'(coin != 2'b00) + int'(cancel_out) + int'(coin_reject), 1);
    end

    task automatic set_btns(input logic [3:0] b);
        btn5       = b[0];
        btn10      = b[1];
        btn20      = b[2];
        btn_cancel = b[3];
    endtask

    task automatic press(input logic [3:0] b, input int hold);
        @(negedge clk);
        set_btns(b);
        repeat (hold) @(negedge clk);
        set_btns(4'b0000);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        repeat (2) @(posedge clk);
        #1;
        while (busy && n < 100) begin
            @(posedge clk);
            #1;
            n++;
        end
        check("idle_reached", int'(busy), 0);
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic wait_coin();
        int n;
        n = 0;
        while (coin == 2'b00 && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
    endtask

    initial begin
        int c0, k0, r0;
        logic [7:0] a0;

        tbl[0] = '{4'b0010, 1'b1, 2'b10, 1, 0, 0, 1};
        tbl[1] = '{4'b0001, 1'b1, 2'b01, 1, 0, 0, 1};
        tbl[2] = '{4'b0100, 1'b1, 2'b11, 1, 0, 0, 1};
        tbl[3] = '{4'b0101, 1'b1, 2'b00, 0, 0, 1, 0};
        tbl[4] = '{4'b0001, 1'b1, 2'b01, 1, 0, 0, 1};
        tbl[5] = '{4'b1010, 1'b1, 2'b00, 0, 1, 0, 0};
        tbl[6] = '{4'b1000, 1'b0, 2'b00, 0, 1, 0, 0};
        tbl[7] = '{4'b0111, 1'b1, 2'b00, 0, 0, 1, 0};
        tbl[8] = '{4'b0001, 1'b0, 2'b00, 0, 0, 0, 0};
        tbl[9] = '{4'b1111, 1'b1, 2'b00, 0, 1, 0, 0};

        reset  = 1'b0;
        enable = 1'b0;
        set_btns(4'b0000);
        repeat (3) @(negedge clk);
        check("reset_outputs", int'({coin, cancel_out, coin_reject, busy, accept_count}), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Clean press: edge E0 is the first posedge after btn10 rises
        enable = 1'b1;
        c0 = n_coin;
        @(negedge clk);
        btn10 = 1'b1;
        for (int k = 0; k < 6; k++) begin
            @(posedge clk);
            #1;
            check($sformatf("clean_early_e%0d", k), int'(coin), 0);
        end
        @(posedge clk);
        #1;
        check("clean_coin_e6", int'(coin), 2);
        check("clean_busy", int'(busy), 1);
        @(posedge clk);
        #1;
        check("clean_coin_e7", int'(coin), 0);
        repeat (12) @(negedge clk);
        btn10 = 1'b0;
        wait_idle();
        check("clean_count", int'(accept_count), 1);
        check("clean_pulses", n_coin - c0, 1);

        // Table of single press scenarios
        for (int i = 0; i < 10; i++) begin
            c0 = n_coin;
            k0 = n_cancel;
            r0 = n_reject;
            a0 = accept_count;
            enable = tbl[i].en;
            press(tbl[i].btns, 12);
            wait_idle();
            check($sformatf("vec%0d_coin_pulses", i), n_coin - c0, tbl[i].n_coin);
            check($sformatf("vec%0d_cancel_pulses", i), n_cancel - k0, tbl[i].n_cancel);
            check($sformatf("vec%0d_reject_pulses", i), n_reject - r0, tbl[i].n_rej);
            check($sformatf("vec%0d_count_delta", i), int'(8'(accept_count - a0)), tbl[i].inc);
            if (tbl[i].n_coin > 0)
                check($sformatf("vec%0d_code", i), int'(last_coin), int'(tbl[i].code));
        end

        // Glitch rejection: five 3-cycle pulses on btn20
        enable = 1'b1;
        c0 = n_coin;
        a0 = accept_count;
        repeat (5) begin
            @(negedge clk);
            btn20 = 1'b1;
            repeat (3) @(negedge clk);
            btn20 = 1'b0;
            repeat (4) @(negedge clk);
        end
        repeat (10) @(negedge clk);
        check("glitch_pulses", n_coin - c0, 0);
        check("glitch_count", int'(accept_count), int'(a0));
        check("glitch_busy", int'(busy), 0);

        // Disabled press: enable rises while still held, press stays discarded
        enable = 1'b0;
        c0 = n_coin;
        a0 = accept_count;
        @(negedge clk);
        btn5 = 1'b1;
        repeat (12) @(negedge clk);
        enable = 1'b1;
        repeat (10) @(negedge clk);
        btn5 = 1'b0;
        wait_idle();
        check("disabled_pulses", n_coin - c0, 0);
        check("disabled_count", int'(accept_count), int'(a0));
        press(4'b0001, 12);
        wait_idle();
        check("reenabled_pulses", n_coin - c0, 1);
        check("reenabled_code", int'(last_coin), 1);
        check("reenabled_count", int'(8'(accept_count - a0)), 1);

        // Counter wrap from a fresh reset
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("wrap_reset_count", int'(accept_count), 0);
        reset = 1'b1;
        repeat (2) @(negedge clk);
        c0 = n_coin;
        for (int i = 0; i < 255; i++) begin
            press(4'b0001, 10);
            wait_idle();
        end
        check("wrap_count_255", int'(accept_count), 255);
        press(4'b0001, 10);
        wait_idle();
        check("wrap_count_0", int'(accept_count), 0);
        check("wrap_pulses", n_coin - c0, 256);

        // Reset while a pulse is in flight, button kept held through reset
        @(negedge clk);
        btn10 = 1'b1;
        wait_coin();
        check("mid_pulse_coin", int'(coin), 2);
        check("mid_pulse_count", int'(accept_count), 1);
        reset = 1'b0;
        #1;
        check("mid_reset_coin", int'(coin), 0);
        check("mid_reset_busy", int'(busy), 0);
        check("mid_reset_count", int'(accept_count), 0);
        @(negedge clk);
        reset = 1'b1;
        wait_coin();
        check("held_repress_coin", int'(coin), 2);
        check("held_repress_count", int'(accept_count), 1);
        @(negedge clk);
        btn10 = 1'b0;
        wait_idle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
